// File: rtl/ysyx_25040109_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory slave between fetch (I) and data (D) channels.
// Define ARB_TIMEOUT_EN to add a response-wait timeout with a sticky arb_err flag.
module ysyx_25040109_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ren,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rvalid,
  output logic [DATA_W-1:0] imem_rdata,
  input  logic              dmem_ren,
  input  logic [ADDR_W-1:0] dmem_raddr,
  output logic              dmem_rvalid,
  output logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_waddr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [2:0]        dmem_wlen,
  output logic              dmem_wready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_wlen,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;  // 1: D won the most recent grant
  logic              own_q, own_d;    // 1: current transaction belongs to D
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        wlen_q, wlen_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;

  logic              i_req, d_req, grant_d;
  logic              resp_take, timeout;
  logic [DATA_W-1:0] resp_data;

  assign i_req     = imem_ren;
  assign d_req     = dmem_wen | dmem_ren;
  assign grant_d   = d_req & (~i_req | ~last_q);
  assign resp_take = mem_resp_valid &
                     (((state_q == StReq) & mem_req_ready) | (state_q == StWait));
  assign resp_data = resp_take ? mem_rdata : DATA_W'(32'hDEADBEEF);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wlen_d   = wlen_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          state_d = StReq;
          last_d  = grant_d;
          own_d   = grant_d;
          if (grant_d) begin
            // A simultaneous read is dropped; the write wins.
            we_d   = dmem_wen;
            addr_d = dmem_wen ? dmem_waddr : dmem_raddr;
            if (dmem_wen) begin
              wdata_d = dmem_wdata;
              wlen_d  = dmem_wlen;
            end
          end else begin
            we_d   = 1'b0;
            addr_d = imem_addr;
          end
        end
      end
      StReq, StWait: begin
        if (resp_take || timeout) begin
          state_d = StResp;
          if (!own_q) begin
            irdata_d = resp_data;
          end else if (!we_q) begin
            drdata_d = resp_data;
          end
        end else if ((state_q == StReq) && mem_req_ready) begin
          state_d = StWait;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wlen_q   <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wlen_q   <= wlen_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  // cnt_q holds the number of REQ/WAIT cycles already elapsed before the current one.
  assign timeout = ((state_q == StReq) || (state_q == StWait)) &&
                   (cnt_q == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == StReq) || (state_q == StWait)) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end
      if (timeout && !resp_take) begin
        err_q <= 1'b1;
      end
    end
  end

  assign arb_err = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign arb_err            = 1'b0;
`endif

  assign mem_req_valid = (state_q == StReq);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wlen      = wlen_q;
  assign imem_rvalid   = (state_q == StResp) & ~own_q;
  assign dmem_rvalid   = (state_q == StResp) & own_q & ~we_q;
  assign dmem_wready   = (state_q == StResp) & own_q & we_q;
  assign imem_rdata    = irdata_q;
  assign dmem_rdata    = drdata_q;

endmodule
